instruction_decoder: RTL and testbench

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

---
 rtl/rv32_decode_pkg.sv | 43 ++++
 rtl/imm_packer.sv | 26 ++
 rtl/instruction_decoder.sv | 61 ++++++
 tb/tb_instruction_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_decode_pkg.sv
// RV32I decode constants: major opcodes and the instruction format code.
package rv32_decode_pkg;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   function automatic fmt_e classify(input logic [6:0] op);
      case (op)
         OP_REG:    return FMT_R;
         OP_IMM,
         OP_LOAD,
         OP_JALR,
         OP_SYSTEM,
         OP_FENCE:  return FMT_I;
         OP_STORE:  return FMT_S;
         OP_BRANCH: return FMT_B;
         OP_LUI,
         OP_AUIPC:  return FMT_U;
         OP_JAL:    return FMT_J;
         default:   return FMT_ILL;
      endcase
   endfunction

endpackage

// File: rtl/imm_packer.sv
// Gathers the scattered immediate bits of each format into a dense,
// zero-padded field; sign extension is left to the consumer.
module imm_packer
   import rv32_decode_pkg::*;
(
   input  logic [31:7] instr,
   input  fmt_e        fmt,
   output logic [19:0] raw_imm
);

   always_comb begin
      raw_imm = '0;
      case (fmt)
         FMT_I: raw_imm = {8'd0, instr[31:20]};
         FMT_S: raw_imm = {8'd0, instr[31:25], instr[11:7]};
         // B and J drop imm[0], which is always zero
         FMT_B: raw_imm = {8'd0, instr[31], instr[7],
                           instr[30:25], instr[11:8]};
         FMT_U: raw_imm = instr[31:12];
         FMT_J: raw_imm = {instr[31], instr[19:12],
                           instr[20], instr[30:21]};
         default: raw_imm = '0;
      endcase
   end

endmodule

// File: rtl/instruction_decoder.sv
// Registered RV32I field decoder: one instruction captured per valid cycle,
// fields and packed immediate presented one cycle later.
module instruction_decoder
   import rv32_decode_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        out_valid,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [19:0] raw_imm,
   output logic [2:0]  fmt,
   output logic        illegal
);

   fmt_e        fmt_d;
   logic [19:0] imm_d;

   assign fmt_d = classify(instr[6:0]);

   imm_packer u_imm_packer (
      .instr   (instr[31:7]),
      .fmt     (fmt_d),
      .raw_imm (imm_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         opcode    <= '0;
         funct3    <= '0;
         funct7    <= '0;
         rs1       <= '0;
         rs2       <= '0;
         rd        <= '0;
         raw_imm   <= '0;
         fmt       <= '0;
         illegal   <= 1'b0;
      end else begin
         out_valid <= instr_valid;
         if (instr_valid) begin
            opcode  <= instr[6:0];
            funct3  <= instr[14:12];
            funct7  <= instr[31:25];
            rs1     <= instr[19:15];
            rs2     <= instr[24:20];
            rd      <= instr[11:7];
            raw_imm <= imm_d;
            fmt     <= fmt_d;
            illegal <= (fmt_d == FMT_ILL);
         end
      end
   end

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder with a scoreboard queue.
module tb_instruction_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [31:0] instr;
   logic        out_valid;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [19:0] raw_imm;
   logic [2:0]  fmt;
   logic        illegal;

   int errors = 0;
   int checks = 0;

   logic [55:0] sb[$];

   instruction_decoder dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .out_valid   (out_valid),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7      (funct7),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .raw_imm     (raw_imm),
      .fmt         (fmt),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [55:0] actual();
      return {opcode, funct3, funct7, rs1, rs2, rd,
              raw_imm, fmt, illegal};
   endfunction

   // reference: rebuild the architectural immediate, then drop bit 0
   function automatic logic [55:0] model(input logic [31:0] i);
      logic [2:0]  f;
      logic [19:0] r;
      logic [12:0] b;
      logic [20:0] j;
      f = 3'd7;
      r = '0;
      b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
      j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
      if (i[6:0] == 7'h33) f = 3'd0;
      if (i[6:0] == 7'h13 || i[6:0] == 7'h03 || i[6:0] == 7'h67 ||
          i[6:0] == 7'h73 || i[6:0] == 7'h0F) f = 3'd1;
      if (i[6:0] == 7'h23) f = 3'd2;
      if (i[6:0] == 7'h63) f = 3'd3;
      if (i[6:0] == 7'h37 || i[6:0] == 7'h17) f = 3'd4;
      if (i[6:0] == 7'h6F) f = 3'd5;
      if (f == 3'd1) r = {8'd0, i[31:20]};
      if (f == 3'd2) r = {8'd0, i[31:25], i[11:7]};
      if (f == 3'd3) r = {8'd0, b[12:1]};
      if (f == 3'd4) r = i[31:12];
      if (f == 3'd5) r = j[20:1];
      return {i[6:0], i[14:12], i[31:25], i[19:15], i[24:20],
              i[11:7], r, f, (f == 3'd7)};
   endfunction

   // drive one valid word at negedge, check the popped expectation after posedge
   task automatic issue(input logic [31:0] w, input string name);
      logic [55:0] exp_v;
      @(negedge clk);
      instr_valid = 1'b1;
      instr = w;
      sb.push_back(model(w));
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || actual() !== exp_v) begin
         errors++;
         $display("FAIL %s: got v=%b %h expected v=1 %h",
                  name, out_valid, actual(), exp_v);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      instr_valid = 1'b0;
      instr = '0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || actual() !== 56'd0) begin
         errors++;
         $display("FAIL reset: got v=%b %h expected all 0",
                  out_valid, actual());
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_r();
      issue(32'b0100000_10101_01010_000_10001_0110011, "r_fmt");
      checks++;
      if ({funct7, rs2, rs1, funct3, rd, fmt, raw_imm} !==
          {7'b0100000, 5'b10101, 5'b01010, 3'b000, 5'b10001,
           3'd0, 20'd0}) begin
         errors++;
         $display("FAIL r_fields: got %h fmt=%0d imm=%h", funct7,
                  fmt, raw_imm);
      end
   endtask

   task automatic test_u();
      issue(32'b00011001110111001010_11100_0010111, "u_fmt");
      checks++;
      if (raw_imm !== 20'h19DCA || rd !== 5'b11100 || fmt !== 3'd4) begin
         errors++;
         $display("FAIL u_fields: got imm=%h rd=%b fmt=%0d expected 19dca 11100 4",
                  raw_imm, rd, fmt);
      end
   endtask

   task automatic test_s();
      issue(32'b1000001_11111_10100_010_01110_0100011, "s_fmt");
      checks++;
      if (raw_imm !== 20'h0082E || rs2 !== 5'b11111 ||
          rs1 !== 5'b10100 || fmt !== 3'd2) begin
         errors++;
         $display("FAIL s_fields: got imm=%h rs2=%b rs1=%b fmt=%0d",
                  raw_imm, rs2, rs1, fmt);
      end
   endtask

   task automatic test_b();
      issue(32'b1001001_01101_00101_110_11001_1100011, "b_fmt");
      checks++;
      if (raw_imm !== 20'h00C9C || funct3 !== 3'b110 || fmt !== 3'd3) begin
         errors++;
         $display("FAIL b_fields: got imm=%h f3=%b fmt=%0d expected 00c9c 110 3",
                  raw_imm, funct3, fmt);
      end
   endtask

   task automatic test_j();
      issue(32'b11010001110111001110_00111_1101111, "j_fmt");
      checks++;
      if (raw_imm !== 20'hE768E || rd !== 5'b00111 || fmt !== 3'd5) begin
         errors++;
         $display("FAIL j_fields: got imm=%h rd=%b fmt=%0d expected e768e 00111 5",
                  raw_imm, rd, fmt);
      end
   endtask

   task automatic test_illegal();
      issue(32'hFFFF_FF80, "illegal");
      checks++;
      if (illegal !== 1'b1 || fmt !== 3'd7 || raw_imm !== 20'd0) begin
         errors++;
         $display("FAIL illegal_fields: got ill=%b fmt=%0d imm=%h expected 1 7 0",
                  illegal, fmt, raw_imm);
      end
   endtask

   task automatic test_hold();
      logic [55:0] held;
      issue(32'h0040_0093, "hold_load");
      held = model(32'h0040_0093);
      @(negedge clk);
      instr_valid = 1'b0;
      instr = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || actual() !== held) begin
         errors++;
         $display("FAIL hold: got v=%b %h expected v=0 %h",
                  out_valid, actual(), held);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops[12];
      logic [31:0] w;
      ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
              7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
      for (int k = 0; k < 24; k++) begin
         w = $urandom;
         w[6:0] = ops[k % 12];
         issue(w, "b2b");
      end
   endtask

   task automatic test_mid_reset();
      issue(32'hFFF0_0F13, "pre_reset");
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || actual() !== 56'd0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b %h expected all 0",
                  out_valid, actual());
      end
      // a word presented during reset must be dropped
      instr_valid = 1'b1;
      instr = 32'h1234_5037;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || actual() !== 56'd0) begin
         errors++;
         $display("FAIL reset_discard: got v=%b %h expected all 0",
                  out_valid, actual());
      end
      issue(32'h1234_5037, "post_reset");
   endtask

   initial begin
      test_reset();
      test_r();
      test_u();
      test_s();
      test_b();
      test_j();
      test_illegal();
      test_hold();
      test_back_to_back();
      test_mid_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0",
                  sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
